// File: rtl/mult_div_unit.sv
// ============================================================================
// mult_div_unit: multi-cycle MIPS multiply/divide unit owning HI/LO.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mult_div_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    logic               busy_q, busy_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] pend_q, pend_d;
    logic               wr_q, wr_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;

    logic               accept;
    logic [2*WIDTH-1:0] a_ext, b_ext, prod;
    logic               neg0, neg1;
    logic [WIDTH-1:0]   mag0, mag1, quot_mag, rem_mag, quot, rem;

    // Division runs on magnitudes so the most-negative / -1 case wraps to
    // the most-negative quotient with zero remainder without signed overflow.
    always_comb begin
        a_ext    = (op == OP_MULT) ? {{WIDTH{in0[WIDTH-1]}}, in0} : {{WIDTH{1'b0}}, in0};
        b_ext    = (op == OP_MULT) ? {{WIDTH{in1[WIDTH-1]}}, in1} : {{WIDTH{1'b0}}, in1};
        prod     = a_ext * b_ext;
        neg0     = (op == OP_DIV) && in0[WIDTH-1];
        neg1     = (op == OP_DIV) && in1[WIDTH-1];
        mag0     = neg0 ? (~in0 + 1'b1) : in0;
        mag1     = neg1 ? (~in1 + 1'b1) : in1;
        if (mag1 == '0) begin
            quot_mag = '0;
            rem_mag  = '0;
        end else begin
            quot_mag = mag0 / mag1;
            rem_mag  = mag0 % mag1;
        end
        quot     = (neg0 ^ neg1) ? (~quot_mag + 1'b1) : quot_mag;
        rem      = neg0 ? (~rem_mag + 1'b1) : rem_mag;
    end

    assign accept = start && !busy_q;

    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        pend_d = pend_q;
        wr_d   = wr_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        if (accept) begin
            case (op)
                OP_MULT, OP_MULTU: begin
                    pend_d = prod;
                    wr_d   = 1'b1;
                    cnt_d  = CW'(MULT_CYCLES);
                    busy_d = 1'b1;
                end
                OP_DIV, OP_DIVU: begin
                    pend_d = {rem, quot};
                    wr_d   = (in1 != '0);
                    cnt_d  = CW'(DIV_CYCLES);
                    busy_d = 1'b1;
                end
                OP_MTHI: hi_d = in0;
                OP_MTLO: lo_d = in0;
                default: ;
            endcase
        end else if (busy_q) begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                busy_d = 1'b0;
                if (wr_q) begin
                    hi_d = pend_q[2*WIDTH-1:WIDTH];
                    lo_d = pend_q[WIDTH-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            pend_q <= '0;
            wr_q   <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
            wr_q   <= wr_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
        end
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_mult_div_unit.sv
// ============================================================================
// tb_mult_div_unit: scoreboard bench for mult_div_unit (directed vectors).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] in0, in1;
    logic        busy;
    logic [31:0] hi, lo;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] sb_q[$];
    logic        skip_fall = 1'b0;
    logic        busy_prev = 1'b0;
    logic [31:0] m_hi = '0, m_lo = '0;

    mult_div_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .in0   (in0),
        .in1   (in1),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every falling edge of busy presents a result for the scoreboard.
    always @(negedge clk) begin
        if (busy_prev === 1'b1 && busy === 1'b0 && !skip_fall) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_result", {hi, lo}, 64'hx);
            end else begin
                chk("sb_hilo", {hi, lo}, sb_q.pop_front());
            end
        end
        busy_prev = busy;
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; op = o; in0 = a; in1 = b;
        @(negedge clk);
        start = 1'b0; op = 3'b000; in0 = $urandom; in1 = $urandom;
    endtask

    task automatic run_md(input string nm, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                          input int n, input bit inject);
        int   cnt;
        logic held;
        sb_q.push_back({eh, el});
        issue(o, a, b);
        cnt  = 0;
        held = 1'b1;
        while (busy === 1'b1 && cnt < 200) begin
            cnt++;
            if (hi !== m_hi || lo !== m_lo) held = 1'b0;
            if (inject && cnt == 2) begin
                start = 1'b1; op = 3'b101; in0 = 32'h0000AAAA; in1 = 32'h0;
            end else if (inject && cnt == 3) begin
                start = 1'b1; op = 3'b100; in0 = 32'd9; in1 = 32'd2;
            end else if (inject && cnt == 4) begin
                start = 1'b0; op = 3'b000;
            end
            @(negedge clk);
        end
        chk({nm, "_busy_cycles"}, 64'(cnt), 64'(n));
        chk({nm, "_hilo_held"}, {63'd0, held}, 64'd1);
        m_hi = eh;
        m_lo = el;
    endtask

    task automatic move(input string nm, input logic [2:0] o, input logic [31:0] d);
        issue(o, d, 32'h0);
        if (o == 3'b101) m_hi = d; else m_lo = d;
        chk({nm, "_hilo"}, {hi, lo}, {m_hi, m_lo});
        chk({nm, "_busy"}, {63'd0, busy}, 64'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = 3'b000; in0 = '0; in1 = '0;
        repeat (3) @(negedge clk);
        chk("reset_state", {31'd0, busy, hi, lo}, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        run_md("mult_neg", 3'b001, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 5, 1'b0);
        run_md("multu", 3'b010, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE, 5, 1'b0);
        run_md("mult_mix", 3'b001, 32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000, 5, 1'b0);
        run_md("div_neg", 3'b011, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10, 1'b0);
        run_md("div_negdiv", 3'b011, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10, 1'b0);
        run_md("divu", 3'b100, 32'd7, 32'd2, 32'd1, 32'd3, 10, 1'b0);

        move("mthi", 3'b101, 32'h00001234);
        move("mtlo", 3'b110, 32'h00005678);
        run_md("divu_by0", 3'b100, 32'd7, 32'd0, 32'h00001234, 32'h00005678, 10, 1'b0);
        run_md("div_ovf", 3'b011, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10, 1'b0);

        // Reserved and none ops must not start anything.
        issue(3'b111, 32'h1, 32'h1);
        chk("reserved_ignored", {31'd0, busy, hi, lo}, {31'd0, 1'b0, m_hi, m_lo});

        // Requests while busy are dropped; first idle cycle accepts.
        run_md("mult_b2b", 3'b001, 32'd6, 32'd7, 32'h0, 32'h0000002A, 5, 1'b1);
        move("mthi_first_idle", 3'b101, 32'h00005555);
        repeat (12) @(negedge clk);
        chk("no_ghost_op", {31'd0, busy, hi, lo}, {31'd0, 1'b0, m_hi, m_lo});

        // Reset on the third busy cycle of a divide.
        issue(3'b011, 32'd100, 32'd7);
        @(negedge clk);
        @(negedge clk);
        chk("abort_in_flight", {63'd0, busy}, 64'd1);
        skip_fall = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_hi = '0; m_lo = '0;
        chk("abort_cleared", {31'd0, busy, hi, lo}, 64'd0);
        repeat (12) @(negedge clk);
        chk("abort_no_late_write", {31'd0, busy, hi, lo}, 64'd0);
        skip_fall = 1'b0;

        // Reset wins over a simultaneous start.
        reset = 1'b1; start = 1'b1; op = 3'b001; in0 = 32'd3; in1 = 32'd3;
        @(negedge clk);
        reset = 1'b0; start = 1'b0; op = 3'b000;
        chk("reset_beats_start", {63'd0, busy}, 64'd0);
        repeat (7) @(negedge clk);
        chk("reset_start_idle", {31'd0, busy, hi, lo}, 64'd0);

        chk("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
